// File: rtl/al_vio_pkg.sv
// Shared types and helpers for the active-list violation RAM.
package al_vio_pkg;

  // Clear engine states
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // Partition index of an address: top part_log bits of an index-bit address.
  function automatic int unsigned part_of(input int unsigned addr,
                                          input int unsigned index,
                                          input int unsigned part_log);
    return (addr >> (index - part_log)) & ((32'd1 << part_log) - 32'd1);
  endfunction

  // Elaboration-time legality of the array geometry.
  function automatic bit params_ok(input int unsigned depth,
                                   input int unsigned index,
                                   input int unsigned num_parts,
                                   input int unsigned part_log);
    return (depth % num_parts == 0) &&
           (index == $clog2(depth)) &&
           ((depth & (depth - 1)) == 0) &&
           ((num_parts & (num_parts - 1)) == 0) &&
           (part_log == $clog2(num_parts)) &&
           (num_parts <= depth);
  endfunction

endpackage

// File: rtl/al_vio_clear_fsm.sv
// Sequential row-clear engine: zeroes the array one row per cycle after
// reset, flush or partition reactivation, and reports when it is usable.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   CLEAR | clearing row clr_ptr each cycle; array not usable
//   READY | array cleared; reads and writes allowed
module al_vio_clear_fsm
  import al_vio_pkg::*;
#(
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned INDEX     = 7,
  parameter int unsigned NUM_PARTS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic [NUM_PARTS-1:0] partition_active_i,
  output logic                 clr_we,
  output logic [INDEX-1:0]     clr_addr,
  output logic                 ready_o,
  output logic                 clr_busy_o
);

  clr_state_e           state_q, state_d;
  logic [INDEX-1:0]     ptr_q, ptr_d;
  logic [NUM_PARTS-1:0] part_q;
  logic                 trigger;

  // Only a partition coming back online needs its stale contents wiped.
  assign trigger = flush_i | (|(partition_active_i & ~part_q));

  // State, pointer and partition-history registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      part_q  <= '1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      part_q  <= partition_active_i;
    end
  end

  // Next-state and clear-pointer sequencing
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        if (trigger) begin
          ptr_d = '0;
        end else if (ptr_q == INDEX'(DEPTH - 1)) begin
          state_d = READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + INDEX'(1);
        end
      end
      READY: begin
        if (trigger) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign clr_we     = (state_q == CLEAR);
  assign clr_addr   = ptr_q;
  assign ready_o    = (state_q == READY);
  assign clr_busy_o = (state_q == CLEAR);

endmodule

// File: rtl/al_vio_ram_mp.sv
// Active-list violation RAM: multi-port write, gated combinational reads,
// sequential clear after reset/flush/partition reactivation.
module al_vio_ram_mp
  import al_vio_pkg::*;
#(
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned INDEX     = 7,
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned NUM_RD    = 4,
  parameter int unsigned NUM_WR    = 2,
  parameter int unsigned NUM_PARTS = 4,
  parameter int unsigned PART_LOG  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_RD-1:0][INDEX-1:0]   rd_addr_i,
  input  logic [NUM_RD-1:0]              rd_port_active_i,
  output logic [NUM_RD-1:0][WIDTH-1:0]   rd_data_o,
  input  logic [NUM_WR-1:0]              wr_en_i,
  input  logic [NUM_WR-1:0][INDEX-1:0]   wr_addr_i,
  input  logic [NUM_WR-1:0][WIDTH-1:0]   wr_data_i,
  input  logic [NUM_PARTS-1:0]           partition_active_i,
  input  logic                           flush_i,
  output logic                           ready_o,
  output logic                           clr_busy_o
);

  if (!params_ok(DEPTH, INDEX, NUM_PARTS, PART_LOG)) begin : g_bad_params
    $error("al_vio_ram_mp: illegal DEPTH/INDEX/NUM_PARTS/PART_LOG combination");
  end

  logic [WIDTH-1:0]    mem [DEPTH];
  logic                clr_we;
  logic [INDEX-1:0]    clr_addr;
  logic [PART_LOG-1:0] rd_part [NUM_RD];
  logic [PART_LOG-1:0] wr_part [NUM_WR];
  logic [NUM_WR-1:0]   wr_ok;

  al_vio_clear_fsm #(
    .DEPTH    (DEPTH),
    .INDEX    (INDEX),
    .NUM_PARTS(NUM_PARTS)
  ) u_clear_fsm (
    .clk               (clk),
    .reset             (reset),
    .flush_i           (flush_i),
    .partition_active_i(partition_active_i),
    .clr_we            (clr_we),
    .clr_addr          (clr_addr),
    .ready_o           (ready_o),
    .clr_busy_o        (clr_busy_o)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_part
    assign rd_part[g] = PART_LOG'(part_of(32'(rd_addr_i[g]), INDEX, PART_LOG));
  end

  for (genvar g = 0; g < NUM_WR; g++) begin : g_wr_part
    assign wr_part[g] = PART_LOG'(part_of(32'(wr_addr_i[g]), INDEX, PART_LOG));
    assign wr_ok[g]   = wr_en_i[g] & partition_active_i[wr_part[g]] & ready_o;
  end

  // Storage update: clear row while clearing, else ports in order so the
  // highest-indexed port wins a same-row collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int w = 0; w < int'(NUM_WR); w++) begin
        if (wr_ok[w]) begin
          mem[wr_addr_i[w]] <= wr_data_i[w];
        end
      end
    end
  end

  // Gated combinational reads; old data is seen during a same-row write.
  always_comb begin
    for (int p = 0; p < int'(NUM_RD); p++) begin
      rd_data_o[p] = '0;
      if (ready_o && rd_port_active_i[p] && partition_active_i[rd_part[p]]) begin
        rd_data_o[p] = mem[rd_addr_i[p]];
      end
    end
  end

endmodule

// File: tb/tb_al_vio_ram_mp.sv
// Scoreboard bench for al_vio_ram_mp: the driver pushes expected read/status
// values and ready-low durations; monitors at negedge pop and compare.
module tb_al_vio_ram_mp;

  localparam int DEPTH = 128;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0][6:0]  rd_addr_i;
  logic [3:0]       rd_port_active_i;
  logic [3:0][1:0]  rd_data_o;
  logic [1:0]       wr_en_i;
  logic [1:0][6:0]  wr_addr_i;
  logic [1:0][1:0]  wr_data_i;
  logic [3:0]       partition_active_i;
  logic             flush_i;
  logic             ready_o;
  logic             clr_busy_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    int         kind;   // 0 = rd_data_o[port], 1 = ready_o, 2 = clr_busy_o
    int         port;
    logic [1:0] val;
  } exp_t;

  exp_t sb[$];
  int   rdy_q[$];
  int   low_cnt = 0;

  al_vio_ram_mp dut (
    .clk               (clk),
    .reset             (reset),
    .rd_addr_i         (rd_addr_i),
    .rd_port_active_i  (rd_port_active_i),
    .rd_data_o         (rd_data_o),
    .wr_en_i           (wr_en_i),
    .wr_addr_i         (wr_addr_i),
    .wr_data_i         (wr_data_i),
    .partition_active_i(partition_active_i),
    .flush_i           (flush_i),
    .ready_o           (ready_o),
    .clr_busy_o        (clr_busy_o)
  );

  always #5 clk = ~clk;

  // Value monitor: drain expectations queued this cycle
  always @(negedge clk) begin : value_monitor
    exp_t       e;
    logic [1:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       act = rd_data_o[e.port];
        1:       act = {1'b0, ready_o};
        default: act = {1'b0, clr_busy_o};
      endcase
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.val);
      end
    end
  end

  // Ready monitor: measure each ready_o low period and compare on the rise
  always @(negedge clk) begin : ready_monitor
    if (reset) begin
      low_cnt = 0;
    end else if (ready_o !== 1'b1) begin
      low_cnt++;
    end else if (low_cnt > 0) begin
      checks++;
      if (rdy_q.size() == 0) begin
        failures++;
        $display("FAIL ready_rise: unexpected rise after %0d low cycles, expected none", low_cnt);
      end else begin
        int exp_low;
        exp_low = rdy_q.pop_front();
        if (low_cnt != exp_low) begin
          failures++;
          $display("FAIL ready_low_len: got %0d low cycles expected %0d", low_cnt, exp_low);
        end
      end
      low_cnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rd(input string name, input int port, input logic [1:0] val);
    exp_t e;
    e.name = name; e.kind = 0; e.port = port; e.val = val;
    sb.push_back(e);
  endtask

  task automatic exp_st(input string name, input int kind, input logic val);
    exp_t e;
    e.name = name; e.kind = kind; e.port = 0; e.val = {1'b0, val};
    sb.push_back(e);
  endtask

  task automatic set_rd(input logic [6:0] a0, input logic [6:0] a1,
                        input logic [6:0] a2, input logic [6:0] a3);
    rd_addr_i[0] = a0; rd_addr_i[1] = a1; rd_addr_i[2] = a2; rd_addr_i[3] = a3;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL %s: ready_o still %b after %0d cycles, expected 1", name, ready_o, n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    set_rd(7'd0, 7'd1, 7'd2, 7'd3);
    rd_port_active_i   = 4'hF;
    wr_en_i            = 2'b00;
    wr_addr_i          = '0;
    wr_data_i          = '0;
    partition_active_i = 4'hF;
    flush_i            = 1'b0;

    // Reset and initial clear sweep
    step();
    reset = 1'b0;
    rdy_q.push_back(DEPTH);
    exp_st("rst_ready", 1, 1'b0);
    exp_st("rst_busy", 2, 1'b1);
    for (int p = 0; p < 4; p++) exp_rd("rst_rd", p, 2'b00);
    for (int i = 1; i < DEPTH; i++) begin
      step();
      exp_st("clr_ready_low", 1, 1'b0);
      exp_rd("clr_rd_zero", i % 4, 2'b00);
    end
    step();
    exp_st("init_ready_high", 1, 1'b1);
    exp_st("init_busy_low", 2, 1'b0);

    // Every row reads 0 after the sweep
    for (int r = 0; r < DEPTH; r += 4) begin
      set_rd(7'(r), 7'(r + 1), 7'(r + 2), 7'(r + 3));
      for (int p = 0; p < 4; p++) exp_rd("init_row_zero", p, 2'b00);
      step();
    end

    // Write collision: port 1 wins; same-cycle read sees old value
    wr_en_i = 2'b11;
    wr_addr_i[0] = 7'd5; wr_data_i[0] = 2'b01;
    wr_addr_i[1] = 7'd5; wr_data_i[1] = 2'b10;
    set_rd(7'd5, 7'd0, 7'd0, 7'd0);
    exp_rd("collide_same_cycle", 0, 2'b00);
    step();
    wr_en_i = 2'b00;
    exp_rd("collide_winner", 0, 2'b10);
    step();

    // Read-port gating
    wr_en_i = 2'b01; wr_addr_i[0] = 7'd9; wr_data_i[0] = 2'b01;
    step();
    wr_en_i = 2'b00;
    set_rd(7'd9, 7'd9, 7'd9, 7'd9);
    rd_port_active_i = 4'b0101;
    exp_rd("port_gate_p0", 0, 2'b01);
    exp_rd("port_gate_p1", 1, 2'b00);
    exp_rd("port_gate_p2", 2, 2'b01);
    exp_rd("port_gate_p3", 3, 2'b00);
    step();
    rd_port_active_i = 4'hF;

    // Partition gating, dropped write, reactivation clear
    wr_en_i = 2'b01; wr_addr_i[0] = 7'd40; wr_data_i[0] = 2'b11;
    step();
    wr_en_i = 2'b00;
    set_rd(7'd40, 7'd9, 7'd0, 7'd0);
    exp_rd("part_pre_gate", 0, 2'b11);
    step();
    partition_active_i = 4'b1101;
    exp_rd("part_gated_rd", 0, 2'b00);
    exp_rd("part_other_rd", 1, 2'b01);
    wr_en_i = 2'b01; wr_addr_i[0] = 7'd33; wr_data_i[0] = 2'b11;
    step();
    wr_en_i = 2'b00;
    exp_st("part_fall_no_clear", 1, 1'b1);
    step();
    partition_active_i = 4'hF;
    set_rd(7'd33, 7'd40, 7'd0, 7'd0);
    exp_rd("part_drop_33", 0, 2'b00);
    exp_rd("part_hold_40", 1, 2'b11);
    rdy_q.push_back(DEPTH);
    step();
    exp_st("part_rise_ready_low", 1, 1'b0);
    exp_rd("part_rise_rd_zero", 1, 2'b00);
    wait_ready("part_reclear");
    set_rd(7'd40, 7'd33, 7'd0, 7'd0);
    exp_rd("part_40_cleared", 0, 2'b00);
    exp_rd("part_33_zero", 1, 2'b00);
    step();

    // Flush restart at clear cycle 60; writes during clear dropped
    flush_i = 1'b1;
    rdy_q.push_back(60 + DEPTH);
    step();
    flush_i = 1'b0;
    exp_st("flush_busy", 2, 1'b1);
    for (int i = 1; i < 60; i++) begin
      if (i == 30) begin
        wr_en_i = 2'b10; wr_addr_i[1] = 7'd3; wr_data_i[1] = 2'b11;
      end else begin
        wr_en_i = 2'b00;
      end
      step();
    end
    wr_en_i = 2'b00;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 100; i++) step();
    wr_en_i = 2'b01; wr_addr_i[0] = 7'd5; wr_data_i[0] = 2'b11;
    step();
    wr_en_i = 2'b00;
    wait_ready("flush_restart");
    set_rd(7'd5, 7'd3, 7'd0, 7'd0);
    exp_rd("flush_drop_5", 0, 2'b00);
    exp_rd("flush_drop_3", 1, 2'b00);
    step();

    // Write in the flush cycle lands, then gets cleared
    flush_i = 1'b1;
    wr_en_i = 2'b01; wr_addr_i[0] = 7'd127; wr_data_i[0] = 2'b11;
    set_rd(7'd127, 7'd0, 7'd0, 7'd0);
    exp_rd("flush_wr_same_cycle", 0, 2'b00);
    rdy_q.push_back(DEPTH);
    step();
    flush_i = 1'b0;
    wr_en_i = 2'b00;
    exp_st("flush_ready_low", 1, 1'b0);
    wait_ready("flush_wr127");
    exp_rd("flush_127_cleared", 0, 2'b00);
    step();

    // Reset in the middle of a clear restarts the full sweep
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 20; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    rdy_q.push_back(DEPTH);
    exp_st("midrst_busy", 2, 1'b1);
    wait_ready("midrst");
    step();
    step();

    checks++;
    if (rdy_q.size() != 0) begin
      failures++;
      $display("FAIL ready_rise_pending: %0d expected rises not seen, expected 0", rdy_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
